// File: rtl/press_classifier_pkg.sv
// Shared types and elaboration helpers for the button press classifier.
package press_classifier_pkg;

  // Gesture tracking states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    LONG_HOLD = 3'd3,
    RELEASE   = 3'd4
  } press_state_t;

  // Larger of two cycle counts; sizes the shared counter.
  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A cycle-count parameter needs at least two samples to be meaningful.
  function automatic bit cycles_ok(input int unsigned v);
    return v >= 2;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short, long and double presses.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 300
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_in,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held,
  output logic o_busy
);

  localparam int unsigned CNT_WIDTH = $clog2(max_of(LONG_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Reject thresholds too small to distinguish gestures.
  if (!cycles_ok(LONG_CYCLES)) begin : g_long_bad
    $error("press_classifier: LONG_CYCLES must be at least 2");
  end
  if (!cycles_ok(GAP_CYCLES)) begin : g_gap_bad
    $error("press_classifier: GAP_CYCLES must be at least 2");
  end

  press_state_t          state;
  logic [CNT_WIDTH-1:0]  cnt;

  // Gesture FSM with inline sample counter; every output is registered.
  // Reset parks in RELEASE so a button held through reset is ignored.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= RELEASE;
      cnt      <= '0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_double <= 1'b0;
      o_held   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_double <= 1'b0;
      o_held   <= 1'b0;
      o_busy   <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_in) begin
            state <= PRESS1;
            cnt   <= CNT_ONE;
          end else begin
            o_busy <= 1'b0;
          end
        end
        PRESS1: begin
          if (i_in) begin
            if (cnt == LONG_LAST) begin
              state  <= LONG_HOLD;
              cnt    <= '0;
              o_long <= 1'b1;
              o_held <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state <= GAP;
            cnt   <= CNT_ONE;
          end
        end
        GAP: begin
          if (i_in) begin
            state    <= RELEASE;
            o_double <= 1'b1;
          end else if (cnt == GAP_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            o_short <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        LONG_HOLD: begin
          if (!i_in) begin
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else begin
            o_held <= 1'b1;
          end
        end
        RELEASE: begin
          if (!i_in) begin
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_CYCLES=8, GAP_CYCLES=4.
module tb_press_classifier;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_in = 1'b0;
  logic o_short, o_long, o_double, o_held, o_busy;

  int assertions = 0;
  int failures   = 0;

  // Expected output vectors, bit order {short, long, double, held, busy}.
  localparam logic [4:0] E_IDLE  = 5'b00000;
  localparam logic [4:0] E_BUSY  = 5'b00001;
  localparam logic [4:0] E_SHORT = 5'b10000;
  localparam logic [4:0] E_LONG  = 5'b01011;
  localparam logic [4:0] E_HELD  = 5'b00011;
  localparam logic [4:0] E_DBL   = 5'b00101;

  press_classifier #(
    .LONG_CYCLES(8),
    .GAP_CYCLES (4)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .i_in    (i_in),
    .o_short (o_short),
    .o_long  (o_long),
    .o_double(o_double),
    .o_held  (o_held),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {o_short, o_long, o_double, o_held, o_busy};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (short long double held busy)", tag, got, exp);
    end
  endtask

  // Drive one sample, let it be clocked in, then compare the registered outputs.
  task automatic step(input logic v, input logic [4:0] exp, input string tag);
    i_in = v;
    @(posedge clk);
    #1;
    check(tag, outs(), exp);
  endtask

  // Repeat one sample value n times with the same expectation.
  task automatic steps(input int n, input logic v, input logic [4:0] exp, input string tag);
    for (int k = 0; k < n; k++) step(v, exp, $sformatf("%s[%0d]", tag, k));
  endtask

  initial begin
    // 1: reset with button held; nothing reported until released.
    i_in = 1'b1;
    i_reset = 1'b1;
    #1;
    check("t1_reset", outs(), E_IDLE);
    @(posedge clk); #1;
    check("t1_reset_edge", outs(), E_IDLE);
    i_reset = 1'b0;
    steps(20, 1'b1, E_BUSY, "t1_held");
    step(1'b0, E_IDLE, "t1_release");
    steps(2, 1'b0, E_IDLE, "t1_idle");

    // 2: short press.
    steps(3, 1'b1, E_BUSY, "t2_high");
    steps(3, 1'b0, E_BUSY, "t2_gap");
    step(1'b0, E_SHORT, "t2_short");
    step(1'b0, E_IDLE, "t2_after");

    // 3: long press.
    steps(7, 1'b1, E_BUSY, "t3_high");
    step(1'b1, E_LONG, "t3_long");
    steps(4, 1'b1, E_HELD, "t3_held");
    step(1'b0, E_IDLE, "t3_release");
    steps(2, 1'b0, E_IDLE, "t3_idle");

    // 4: double press with a long second press.
    steps(2, 1'b1, E_BUSY, "t4_p1");
    steps(2, 1'b0, E_BUSY, "t4_gap");
    step(1'b1, E_DBL, "t4_double");
    steps(19, 1'b1, E_BUSY, "t4_p2");
    step(1'b0, E_IDLE, "t4_release");
    step(1'b0, E_IDLE, "t4_idle");

    // 5a: gap just long enough -> short, next press starts fresh.
    steps(2, 1'b1, E_BUSY, "t5a_p1");
    steps(3, 1'b0, E_BUSY, "t5a_gap");
    step(1'b0, E_SHORT, "t5a_short");
    step(1'b1, E_BUSY, "t5a_fresh");
    steps(3, 1'b0, E_BUSY, "t5a_gap2");
    step(1'b0, E_SHORT, "t5a_short2");
    step(1'b0, E_IDLE, "t5a_idle");

    // 5b: gap one sample short -> double.
    steps(2, 1'b1, E_BUSY, "t5b_p1");
    steps(3, 1'b0, E_BUSY, "t5b_gap");
    step(1'b1, E_DBL, "t5b_double");
    step(1'b0, E_IDLE, "t5b_release");
    step(1'b0, E_IDLE, "t5b_idle");

    // 6: reset in the middle of a press.
    steps(6, 1'b1, E_BUSY, "t6_high");
    i_reset = 1'b1;
    #1;
    check("t6_async_reset", outs(), E_IDLE);
    @(posedge clk); #1;
    check("t6_reset_edge", outs(), E_IDLE);
    i_reset = 1'b0;
    steps(10, 1'b1, E_BUSY, "t6_held");
    step(1'b0, E_IDLE, "t6_release");
    steps(2, 1'b1, E_BUSY, "t6_p");
    steps(3, 1'b0, E_BUSY, "t6_gap");
    step(1'b0, E_SHORT, "t6_short");
    step(1'b0, E_IDLE, "t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Consumes the clean level produced by the debouncer (its o_out) and classifies each button gesture as short press, long press or double press.
- Emits one-cycle event pulses plus a held-level flag.
- Sits between the debouncer and the control/UI logic, in the same clock domain, with no synchroniser needed.

Parameters:
- LONG_CYCLES, 1000: consecutive high samples that make a press "long"; must be ≥2 (elaboration-time check).
- GAP_CYCLES, 300: consecutive low samples after a short press within which a second press counts as a double; must be ≥2.
- CNT_WIDTH (localparam): $clog2(max(LONG_CYCLES, GAP_CYCLES)) + 1.

Ports:
- clk, input, 1: system clock; all state is updated on the rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_in, input, 1: debounced button level, 1 = pressed.
- o_short, output, 1: one-cycle pulse, single short press confirmed.
- o_long, output, 1: one-cycle pulse, long press threshold reached.
- o_double, output, 1: one-cycle pulse, second press inside the gap window.
- o_held, output, 1: high while in LONG_HOLD.
- o_busy, output, 1: high whenever state ≠ IDLE.

Behaviour:
- All outputs are registered.
- On reset, all outputs are 0, cnt = 0 and state = RELEASE. Reset takes effect asynchronously and mid-gesture; no pulse is ever emitted because of reset.
- States: IDLE, PRESS1, GAP, LONG_HOLD, RELEASE. "Sample" means the value of i_in at a rising clk edge.
- IDLE:
  - high sample → PRESS1, cnt ← 1.
  - otherwise stay.
- PRESS1:
  - high sample with cnt == LONG_CYCLES-1 → LONG_HOLD, o_long ← 1 for one cycle, cnt ← 0.
  - high sample otherwise → cnt++.
  - low sample → GAP, cnt ← 1.
  - Net effect: o_long rises on the edge of the LONG_CYCLES-th consecutive high sample.
- GAP:
  - high sample → RELEASE, o_double ← 1 for one cycle.
  - low sample with cnt == GAP_CYCLES-1 → IDLE, o_short ← 1 for one cycle, cnt ← 0.
  - low sample otherwise → cnt++.
  - Net effect: o_short rises on the edge of the GAP_CYCLES-th consecutive low sample after release.
- LONG_HOLD: o_held = 1. Low sample → IDLE; o_held falls on that edge. No short pulse is emitted on release.
- RELEASE: waits for a low sample, then → IDLE. A second press is never classified further, whatever its length.
- Reset with i_in held high stays in RELEASE, so no press is reported until the button has been released and pressed again.
- At most one of o_short / o_long / o_double is high in any cycle, and each gesture yields exactly one event.
- A press beginning on the sample immediately after o_short (state IDLE) is a fresh PRESS1, never a double.
- cnt never exceeds max(LONG_CYCLES, GAP_CYCLES)-1 and is cleared on every state change into IDLE or LONG_HOLD.

Decomposition:
- press_classifier_pkg holds the state enum typedef (press_state_t) and a shared width-check function used for the elaboration assertions.
- No sub-module: the edge detection is implicit in the FSM and the single counter is inline.

Test Plan (LONG_CYCLES=8, GAP_CYCLES=4, 10 ns clk):
1. Reset with i_in=1, hold i_in high for 20 cycles, then drop it → o_busy=1 throughout, no pulses; o_busy falls one edge after the first low sample.
2. Short press: 3 high samples, then low → o_short high for exactly one cycle on the 4th low-sample edge; o_long, o_double and o_held stay 0; o_busy falls with o_short.
3. Long press: 12 high samples → o_long pulses on the 8th high edge; o_held is 1 from that edge until the first low-sample edge; o_short is never asserted.
4. Double press: 2 high, 2 low, 1 high → o_double pulses on the edge of the first high sample of the second press; o_busy stays 1 until the release sample; o_short and o_long are never asserted, even if the second press lasts 20 cycles.
5. Gap boundary:
   - 2 high, exactly 4 low, then high → o_short on the 4th low edge, the next press enters PRESS1 and no o_double is emitted.
   - Repeating with 3 low samples instead → o_double and no o_short.
6. Reset mid-press: assert i_reset after 6 high samples and release it while i_in is still high, then keep i_in high for 10 more cycles → all outputs 0 immediately on reset, no o_long, and a later release followed by a 2-sample press gives a normal short-press sequence.
